// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer: register indices,
// CTRL field layout, mode encodings and FSM state encoding.
package timer_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] IDX_CTRL   = 2'd0;
  localparam logic [1:0] IDX_PRESET = 2'd1;
  localparam logic [1:0] IDX_COUNT  = 2'd2;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  // Field order mirrors the CTRL bit positions above (IM=3, MODE=2:1, EN=0).
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  // Encodings 10/11 behave as one-shot, so only 01 selects auto-reload.
  function automatic logic is_reload(input logic [1:0] mode);
    return (mode == MODE_RELOAD);
  endfunction

endpackage

// File: rtl/timer_regfile.sv
// CTRL/PRESET storage, write decode and combinational read mux for the timer.
// A software CTRL write takes priority over the hardware EN clear.
module timer_regfile
  import timer_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [1:0]        addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              we_i,
  input  logic              hw_en_clr_i,
  input  logic [DATA_W-1:0] count_i,
  output logic [DATA_W-1:0] rdata_o,
  output ctrl_t             ctrl_o,
  output logic [DATA_W-1:0] preset_o,
  output logic              ctrl_we_o
);

  ctrl_t             ctrl_q, ctrl_d;
  logic [DATA_W-1:0] preset_q, preset_d;
  logic              ctrl_we;
  logic              preset_we;

  assign ctrl_we   = we_i && (addr_i == IDX_CTRL);
  assign preset_we = we_i && (addr_i == IDX_PRESET);

  always_comb begin
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    if (ctrl_we) begin
      ctrl_d = ctrl_t'(wdata_i[CTRL_IM_BIT:CTRL_EN_BIT]);
    end else if (hw_en_clr_i) begin
      ctrl_d.en = 1'b0;
    end
    if (preset_we) begin
      preset_d = wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ctrl_q   <= '0;
      preset_q <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    case (addr_i)
      IDX_CTRL:   rdata_o = {{(DATA_W-4){1'b0}}, ctrl_q};
      IDX_PRESET: rdata_o = preset_q;
      IDX_COUNT:  rdata_o = count_i;
      default:    rdata_o = '0;
    endcase
  end

  assign ctrl_o    = ctrl_q;
  assign preset_o  = preset_q;
  assign ctrl_we_o = ctrl_we;

endmodule

// File: rtl/timer_dev.sv
// 32-bit countdown timer device: IDLE/LOAD/CNT/INT sequencer, COUNT register
// and a pending flag gated by CTRL.IM onto a level interrupt request.
module timer_dev
  import timer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        dev_addr,
  input  logic [DATA_W-1:0] dev_write_data,
  input  logic              dev_write_en,
  output logic [DATA_W-1:0] dev_read_data,
  output logic              int_request
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic              pend_q, pend_d;
  logic              hw_en_clr;
  logic              ctrl_we;
  logic              reload;
  ctrl_t             ctrl;
  logic [DATA_W-1:0] preset;

  timer_regfile u_regfile (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .addr_i      (dev_addr),
    .wdata_i     (dev_write_data),
    .we_i        (dev_write_en),
    .hw_en_clr_i (hw_en_clr),
    .count_i     (count_q),
    .rdata_o     (dev_read_data),
    .ctrl_o      (ctrl),
    .preset_o    (preset),
    .ctrl_we_o   (ctrl_we)
  );

  assign reload = is_reload(ctrl.mode);

  // The CNT->INT pending set is assigned last so it wins over a CTRL-write clear.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    pend_d    = pend_q;
    hw_en_clr = 1'b0;
    if (ctrl_we && !reload) begin
      pend_d = 1'b0;
    end
    case (state_q)
      ST_IDLE: begin
        if (ctrl.en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset;
        state_d = ctrl.en ? ST_CNT : ST_IDLE;
      end
      ST_CNT: begin
        if (!ctrl.en) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d = '0;
          pend_d  = 1'b1;
          state_d = ST_INT;
        end
      end
      ST_INT: begin
        if (reload) begin
          pend_d  = 1'b0;
          state_d = ST_LOAD;
        end else begin
          hw_en_clr = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pend_q  <= pend_d;
    end
  end

  assign int_request = pend_q & ctrl.im;

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: expected values queued as stimulus is applied,
// popped and compared when the corresponding DUT output is sampled.
module tb_timer_dev;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  dev_addr;
  logic [31:0] dev_write_data;
  logic        dev_write_en;
  logic [31:0] dev_read_data;
  logic        int_request;

  logic [31:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  timer_dev dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .dev_addr       (dev_addr),
    .dev_write_data (dev_write_data),
    .dev_write_en   (dev_write_en),
    .dev_read_data  (dev_read_data),
    .int_request    (int_request)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    dev_addr       = a;
    dev_write_data = d;
    dev_write_en   = 1'b1;
    @(posedge clk);
    #1;
    dev_write_en   = 1'b0;
  endtask

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic compare(input string tag, input logic [31:0] obs);
    logic [31:0] exp_v;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: observed %h, expected queue empty", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
    end
  endtask

  task automatic rd(input string tag, input logic [1:0] a);
    dev_addr = a;
    #1;
    compare(tag, dev_read_data);
  endtask

  task automatic irq(input string tag);
    compare(tag, {31'b0, int_request});
  endtask

  initial begin
    // Reset held two cycles while the bus tries to write every register.
    rst_n          = 1'b0;
    dev_write_en   = 1'b1;
    dev_write_data = 32'hFFFF_FFFF;
    dev_addr       = 2'd0;
    @(posedge clk); #1;
    dev_addr = 2'd1;
    @(posedge clk); #1;
    rst_n        = 1'b1;
    dev_write_en = 1'b0;
    push(0); rd("rst_ctrl", 2'd0);
    push(0); rd("rst_preset", 2'd1);
    push(0); rd("rst_count", 2'd2);
    push(0); irq("rst_irq");

    // One-shot, PRESET=5: COUNT 5..0 from T+2, interrupt at T+7.
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    push(0); irq("os_irq_t0");
    for (int k = 0; k < 6; k++) begin
      push(32'(5 - k));
      push({31'b0, k == 5});
    end
    tick(); tick();
    for (int k = 0; k < 6; k++) begin
      rd("os_count", 2'd2);
      irq("os_irq");
      if (k < 5) tick();
    end
    tick(); tick();
    push(32'h8); rd("os_ctrl_after", 2'd0);
    push(1);     irq("os_irq_held");
    wr(2'd0, 32'h8);
    push(0);     irq("os_irq_cleared");

    // Auto-reload, PRESET=3: period 5, COUNT 3,2,1,0 then 0 during LOAD.
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int c = 0; c < 15; c++) begin
      case (c % 5)
        0: push(3);
        1: push(2);
        2: push(1);
        default: push(0);
      endcase
      push({31'b0, (c % 5) == 3});
    end
    tick(); tick();
    for (int c = 0; c < 15; c++) begin
      rd("ar_count", 2'd2);
      irq("ar_irq");
      if (c < 14) tick();
    end
    wr(2'd0, 32'h0);
    tick();
    push(3); rd("ar_stop_count", 2'd2);
    push(0); irq("ar_stop_irq");

    // Masked expiry: pending sets silently, later CTRL write clears it.
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    for (int c = 0; c < 6; c++) begin
      push(0); irq("mask_irq");
      tick();
    end
    push(0);   rd("mask_ctrl_en_clr", 2'd0);
    wr(2'd0, 32'h8);
    tick();
    push(0);   irq("mask_irq_after_im");
    push(8);   rd("mask_ctrl", 2'd0);

    // Stop at COUNT=6, hold, then restart through LOAD.
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    tick(); tick();
    push(10); rd("ss_count_start", 2'd2);
    tick(); tick(); tick();
    push(7);  rd("ss_count_7", 2'd2);
    wr(2'd0, 32'h0);
    push(6);  rd("ss_count_6", 2'd2);
    for (int c = 0; c < 4; c++) begin
      tick();
      push(6); rd("ss_hold", 2'd2);
    end
    wr(2'd0, 32'h1);
    tick();
    push(6);  rd("ss_load_cycle", 2'd2);
    tick();
    push(10); rd("ss_reloaded", 2'd2);
    tick();
    push(9);  rd("ss_dec", 2'd2);
    wr(2'd0, 32'h0);
    tick();
    push(8);  rd("ss_stopped", 2'd2);

    // COUNT read-only, idx3 reads zero, PRESET reads back.
    wr(2'd2, 32'h0000_FFFF);
    push(8);  rd("cnt_ro", 2'd2);
    wr(2'd3, 32'hDEAD_BEEF);
    push(0);  rd("idx3_zero", 2'd3);
    push(10); rd("preset_rb", 2'd1);
    wr(2'd0, 32'hFFFF_FFF0);
    push(0);  rd("ctrl_upper_ignored", 2'd0);

    // PRESET=0: interrupt three cycles after the EN write.
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    tick(); push(0); irq("p0_irq_t1");
    tick(); push(0); irq("p0_irq_t2");
    tick(); push(1); irq("p0_irq_t3");
    tick(); push(1); irq("p0_irq_held");
    push(8); rd("p0_ctrl", 2'd0);
    wr(2'd0, 32'h8);
    push(0); irq("p0_irq_clr");

    // CTRL writes colliding with the pending set and with the EN clear.
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
    tick(); tick(); tick();
    push(1); rd("col_count_1", 2'd2);
    wr(2'd0, 32'h9);
    push(1); irq("col_set_wins");
    wr(2'd0, 32'h9);
    push(9); rd("col_sw_wins", 2'd0);
    push(0); irq("col_pend_clr");
    wr(2'd0, 32'h0);
    tick(); tick();
    push(2); rd("col_count_reload", 2'd2);
    push(0); irq("col_irq_idle");

    // Reset in the middle of a count aborts immediately.
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    push(0); rd("mid_rst_count", 2'd2);
    push(0); rd("mid_rst_ctrl", 2'd0);
    push(0); rd("mid_rst_preset", 2'd1);
    tick(); tick(); tick();
    push(0); rd("mid_rst_idle", 2'd2);
    push(0); irq("mid_rst_irq");

    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: observed %0d leftover, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
